serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Multi-cycle, bit-serial subtractor: the inverse operation of the team's ripple adder. It is used for exponent-difference computation in the IEEE adder/subtractor path. It computes reg1 - reg2 one bit per cycle, LSB first, through a single AdderSubtractor cell run in subtract mode. When the result is negative, it runs a second serial pass to produce the absolute difference plus a swap flag for the alignment shifter.

Parameters:
WIDTH, 8, operand/result width in bits; the bit counter is $clog2(WIDTH) bits wide.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
reg1  input  WIDTH  minuend; latched on accepted start
reg2  input  WIDTH  subtrahend; latched on accepted start
busy  output  1  high in SUB and NEG states
done  output  1  one-cycle pulse, high only in DONE state
result  output  WIDTH  (reg1 - reg2) mod 2^WIDTH
borrow  output  1  1 when reg1 < reg2 (unsigned)
abs_diff  output  WIDTH  |reg1 - reg2|
swap  output  1  equals borrow; tells the aligner to swap operands

Behaviour:
- Reset: busy, done, result, borrow, abs_diff and swap are all 0; state = IDLE; counter = 0; carry flop = 0. Reset in any state, mid-pass included, aborts the operation and restores these values on the next edge.
- Arithmetic: A + ~B + carry.
  - SUB pass: carry flop preset to 1 at start; A = latched reg1 bit, B = latched reg2 bit.
  - After bit WIDTH-1: borrow = ~carry_out.
  - NEG pass: carry preset to 1; A = 0, B = result bit. This gives abs_diff = 0 - result.
- FSM:
  - IDLE: start=1 -> latch operands, counter=0, carry=1, clear done -> SUB. start=0 -> stay.
  - SUB: each cycle computes one bit into result[counter] and counter++. On counter == WIDTH-1, capture borrow/swap, then go to NEG if borrow=1, else copy result to abs_diff and go to DONE.
  - NEG: counter restarts at 0, carry=1. Each cycle writes abs_diff[counter]. On counter == WIDTH-1 -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Latency (cycle 0 = the cycle in which start is accepted):
  - SUB occupies cycles 1..WIDTH.
  - No borrow: DONE in cycle WIDTH+1 (9).
  - Borrow: NEG occupies cycles WIDTH+1..2*WIDTH; DONE in cycle 2*WIDTH+1 (17).
- Outputs:
  - result, borrow, abs_diff and swap are valid from the DONE cycle onward.
  - They hold until the next accepted start, which clears them to 0 at the acceptance edge.
  - They are undefined to consumers while busy.
- Boundaries:
  - start while busy or in DONE is ignored; no queueing.
  - Operand input changes after acceptance have no effect.
  - reg1 == reg2: result 0, borrow 0, no NEG pass.
  - 0 - (2^WIDTH-1): result 1, abs_diff 2^WIDTH-1.
  - start held high continuously: a new operation begins in the cycle after DONE, giving back-to-back operation with a 1-cycle IDLE gap.
  - Simultaneous rst and start: rst wins.

Decomposition:
- Shared package (fpu_pkg): state enum (IDLE, SUB, NEG, DONE) and a SUB_OP = 1'b1 constant for the cell's op input.
- Sub-module: exactly one existing AdderSubtractor cell, instantiated once with op tied to SUB_OP. Its A/B/cin inputs are muxed by state; cout feeds the carry flop.
- No new sub-module.

Test Plan:
- reg1=5, reg2=3, start pulse -> done at cycle 9; result=0x02, borrow=0, abs_diff=0x02, swap=0; busy high cycles 1..8.
- reg1=3, reg2=5 -> done at cycle 17; result=0xFE, borrow=1, abs_diff=0x02, swap=1.
- reg1=0x80, reg2=0x80 -> done at cycle 9; result=0, borrow=0, abs_diff=0. Then reg1=0x00, reg2=0xFF -> result=0x01, borrow=1, abs_diff=0xFF.
- Start 7-2, re-pulse start with 9-9 at cycle 4, and change reg1/reg2 mid-pass -> ignored; result=0x05 at cycle 9; done is exactly one cycle wide.
- Start 3-5, assert rst at cycle 12 (during NEG) -> next cycle: all outputs 0, IDLE. New start 10-4 -> result=0x06 at cycle 9 relative to that start.
- Random sweep of 1000 operand pairs with start held high -> each result matches (reg1-reg2) mod 256 and abs_diff matches |reg1-reg2|; exactly one done per op with the 1-cycle IDLE gap.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU-path types: serial subtractor FSM states and cell op codes.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic SUB_OP = 1'b1;

endpackage

// File: rtl/adder_subtractor.sv
// One-bit add/subtract cell: sum = a + (b ^ op) + cin.
module AdderSubtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    input  logic op_i,
    output logic sum_o,
    output logic cout_o
);

    logic bx;

    assign bx     = b_i ^ op_i;
    assign sum_o  = a_i ^ bx ^ cin_i;
    assign cout_o = (a_i & bx) | (a_i & cin_i) | (bx & cin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial reg1 - reg2, LSB first; a negative result gets a second
// serial pass (0 - result) to form the absolute difference.
module serial_subtractor
    import fpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic [WIDTH-1:0] abs_diff,
    output logic             swap
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] abs_q, abs_d;

    logic cell_a, cell_b, cell_sum, cell_cout;

    AdderSubtractor u_cell (
        .a_i    (cell_a),
        .b_i    (cell_b),
        .cin_i  (carry_q),
        .op_i   (SUB_OP),
        .sum_o  (cell_sum),
        .cout_o (cell_cout)
    );

    // SUB feeds the latched operands; NEG computes 0 - result.
    always_comb begin
        cell_a = 1'b0;
        cell_b = 1'b0;
        unique case (state_q)
            SUB: begin
                cell_a = op1_q[cnt_q];
                cell_b = op2_q[cnt_q];
            end
            NEG: begin
                cell_a = 1'b0;
                cell_b = result_q[cnt_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        borrow_d = borrow_q;
        abs_d    = abs_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op1_d    = reg1;
                    op2_d    = reg2;
                    cnt_d    = '0;
                    carry_d  = 1'b1;
                    result_d = '0;
                    borrow_d = 1'b0;
                    abs_d    = '0;
                    state_d  = SUB;
                end
            end
            SUB: begin
                result_d[cnt_q] = cell_sum;
                carry_d         = cell_cout;
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    borrow_d = ~cell_cout;
                    cnt_d    = '0;
                    if (!cell_cout) begin
                        carry_d = 1'b1;
                        state_d = NEG;
                    end else begin
                        abs_d   = result_d;
                        state_d = DONE;
                    end
                end
            end
            NEG: begin
                abs_d[cnt_q] = cell_sum;
                carry_d      = cell_cout;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
            borrow_q <= 1'b0;
            abs_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
            borrow_q <= borrow_d;
            abs_q    <= abs_d;
        end
    end

    assign busy     = (state_q == SUB) || (state_q == NEG);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign borrow   = borrow_q;
    assign abs_diff = abs_q;
    assign swap     = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of the serial subtractor against
// a plain-arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] reg1, reg2;
    logic         busy, done, borrow, swap;
    logic [W-1:0] result, abs_diff;

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .reg1     (reg1),
        .reg2     (reg2),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .borrow   (borrow),
        .abs_diff (abs_diff),
        .swap     (swap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int a, input int b,
                                  output int res, output int brw,
                                  output int ad, output int lat);
        res = (a - b + 256) % 256;
        brw = (a < b) ? 1 : 0;
        ad  = (a >= b) ? a - b : b - a;
        lat = brw ? 2 * W + 1 : W + 1;
    endfunction

    // Advance until done rises (bounded); busy must be high meanwhile.
    task automatic wait_done(input string tag, inout int cyc,
                             input int exp_lat);
        do begin
            @(negedge clk);
            cyc++;
            if (done !== 1'b1)
                check({tag, "_busy"}, 32'(busy), 32'd1);
        end while (done !== 1'b1 && cyc < 40);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    endtask

    task automatic check_outs(input string tag, input int a, input int b);
        int res, brw, ad, lat;
        model(a, b, res, brw, ad, lat);
        check({tag, "_result"}, 32'(result), 32'(res));
        check({tag, "_borrow"}, 32'(borrow), 32'(brw));
        check({tag, "_abs"}, 32'(abs_diff), 32'(ad));
        check({tag, "_swap"}, 32'(swap), 32'(brw));
    endtask

    task automatic run_op(input string tag, input int a, input int b);
        int res, brw, ad, lat, cyc;
        model(a, b, res, brw, ad, lat);
        reg1  = W'(a);
        reg2  = W'(b);
        start = 1'b1;
        cyc   = 0;
        @(negedge clk);
        cyc   = 1;
        start = 1'b0;
        check({tag, "_busy1"}, 32'(busy), 32'd1);
        wait_done(tag, cyc, lat);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_outs(tag, a, b);
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc, a, b, na, nb, res, brw, ad, lat;
        rst   = 1'b1;
        start = 1'b0;
        reg1  = '0;
        reg2  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_abs", 32'(abs_diff), 32'd0);
        check("rst_swap", 32'(swap), 32'd0);
        rst = 1'b0;

        run_op("op5m3", 5, 3);
        run_op("op3m5", 3, 5);
        run_op("eq80", 8'h80, 8'h80);
        run_op("zeroff", 0, 8'hFF);

        // Start while busy and operand changes mid-pass are ignored.
        reg1  = 8'd7;
        reg2  = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        reg1  = 8'd9;
        reg2  = 8'd9;
        @(negedge clk);
        start = 1'b0;
        reg1  = 8'hAA;
        reg2  = 8'h11;
        cyc   = 5;
        wait_done("ign", cyc, W + 1);
        check_outs("ign", 7, 2);
        @(negedge clk);
        check("ign_done_width", 32'(done), 32'd0);
        @(negedge clk);
        check("ign_no_requeue", 32'(busy), 32'd0);

        // Reset during the NEG pass aborts everything.
        reg1  = 8'd3;
        reg2  = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("midneg_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        check("abort_abs", 32'(abs_diff), 32'd0);
        check("abort_swap", 32'(swap), 32'd0);
        run_op("after_rst", 10, 4);

        // Reset beats a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_vs_start", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_vs_start2", 32'(busy), 32'd0);

        // Back-to-back random sweep with start held high.
        a     = int'($urandom_range(255));
        b     = int'($urandom_range(255));
        reg1  = W'(a);
        reg2  = W'(b);
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            model(a, b, res, brw, ad, lat);
            cyc = 0;
            wait_done("rnd", cyc, lat);
            check_outs("rnd", a, b);
            na = int'($urandom_range(255));
            nb = int'($urandom_range(255));
            if (i % 50 == 7) nb = na;
            reg1 = W'(na);
            reg2 = W'(nb);
            if (i == 999) start = 1'b0;
            @(negedge clk);
            check("rnd_gap_done", 32'(done), 32'd0);
            check("rnd_gap_busy", 32'(busy), 32'd0);
            a = na;
            b = nb;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
